xswitch_protocol_monitor: RTL

- Synthesizable, parametrised protocol checker for the N-port crossbar switch.
- Sits passively on all downstream (valid_in/addr_in/data_in/rcv_rdy) and upstream (valid_out/addr_out/data_out/data_rd) signals.
- Checks routing, data integrity, source-address tagging and the read/ready handshake within a configurable latency window.
- Keeps sticky error flags, saturating pass/fail counters and a first-error capture, for use in emulation and as a coverage source.

---
 rtl/xswitch_protocol_monitor.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/xswitch_protocol_monitor.sv
// Passive checker for the N-port crossbar: routing, data, source tag and read/ready handshake.
// Keeps sticky error flags, saturating pass/fail counters and a first-error capture.
module xswitch_protocol_monitor #(
    parameter int N_PORTS = 4,
    parameter int ADDR_W  = 2,
    parameter int DATA_W  = 8,
    parameter int MAX_LAT = 0,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic                      clr,
    input  logic [N_PORTS-1:0]        valid_in,
    input  logic [N_PORTS*ADDR_W-1:0] addr_in,
    input  logic [N_PORTS*DATA_W-1:0] data_in,
    input  logic [N_PORTS-1:0]        rcv_rdy,
    input  logic [N_PORTS-1:0]        valid_out,
    input  logic [N_PORTS*ADDR_W-1:0] addr_out,
    input  logic [N_PORTS*DATA_W-1:0] data_out,
    input  logic [N_PORTS-1:0]        data_rd,
    output logic [4:0]                err_sticky,
    output logic [CNT_W-1:0]          pass_cnt,
    output logic [CNT_W-1:0]          fail_cnt,
    output logic                      err_valid,
    output logic [2:0]                first_err_code,
    output logic [ADDR_W-1:0]         first_err_port
);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_WAIT = 1'b1;
    localparam logic [3:0] LAT = 4'(MAX_LAT);

    logic [N_PORTS-1:0] ost_q, ost_d;
    logic [ADDR_W-1:0]  src_q [N_PORTS];
    logic [ADDR_W-1:0]  src_d [N_PORTS];
    logic [DATA_W-1:0]  dat_q [N_PORTS];
    logic [DATA_W-1:0]  dat_d [N_PORTS];
    logic [3:0]         otmr_q [N_PORTS];
    logic [3:0]         otmr_d [N_PORTS];
    logic [N_PORTS-1:0] rst_q, rst_d;
    logic [3:0]         rtmr_q [N_PORTS];
    logic [3:0]         rtmr_d [N_PORTS];

    logic [N_PORTS-1:0] ev_opass, ev_vto, ev_dmis, ev_amis, ev_con, ev_rpass, ev_rto;

    logic [4:0]         err_sticky_q, err_sticky_d;
    logic [CNT_W-1:0]   pass_cnt_q, pass_cnt_d, fail_cnt_q, fail_cnt_d;
    logic               err_valid_q, err_valid_d;
    logic [2:0]         first_err_code_q, first_err_code_d;
    logic [ADDR_W-1:0]  first_err_port_q, first_err_port_d;

    always_comb begin
        logic              hit, multi, do_cmp;
        logic [ADDR_W-1:0] rsrc, cmp_src;
        logic [DATA_W-1:0] rdat, cmp_dat;
        for (int unsigned j = 0; j < N_PORTS; j++) begin
            ost_d[j]    = ost_q[j];
            src_d[j]    = src_q[j];
            dat_d[j]    = dat_q[j];
            otmr_d[j]   = otmr_q[j];
            ev_opass[j] = 1'b0;
            ev_vto[j]   = 1'b0;
            ev_dmis[j]  = 1'b0;
            ev_amis[j]  = 1'b0;
            ev_con[j]   = 1'b0;
            hit         = 1'b0;
            multi       = 1'b0;
            rsrc        = '0;
            rdat        = '0;
            // Lowest-index requester wins; any further requester marks contention.
            for (int unsigned i = 0; i < N_PORTS; i++) begin
                if (valid_in[i] && addr_in[i*ADDR_W +: ADDR_W] == ADDR_W'(j)) begin
                    if (hit) begin
                        multi = 1'b1;
                    end else begin
                        rsrc = ADDR_W'(i);
                        rdat = data_in[i*DATA_W +: DATA_W];
                    end
                    hit = 1'b1;
                end
            end
            do_cmp  = 1'b0;
            cmp_src = src_q[j];
            cmp_dat = dat_q[j];
            if (!en) begin
                ost_d[j] = ST_IDLE;
            end else if (ost_q[j] == ST_IDLE) begin
                if (hit) begin
                    ev_con[j] = multi;
                    if (valid_out[j]) begin
                        do_cmp  = 1'b1;
                        cmp_src = rsrc;
                        cmp_dat = rdat;
                    end else if (MAX_LAT == 0) begin
                        ev_vto[j] = 1'b1;
                    end else begin
                        src_d[j]  = rsrc;
                        dat_d[j]  = rdat;
                        otmr_d[j] = 4'd1;
                        ost_d[j]  = ST_WAIT;
                    end
                end
            end else begin
                ev_con[j] = hit;
                if (valid_out[j]) begin
                    do_cmp   = 1'b1;
                    ost_d[j] = ST_IDLE;
                end else if (otmr_q[j] == LAT) begin
                    ev_vto[j] = 1'b1;
                    ost_d[j]  = ST_IDLE;
                end else begin
                    otmr_d[j] = otmr_q[j] + 4'd1;
                end
            end
            if (do_cmp) begin
                ev_amis[j]  = addr_out[j*ADDR_W +: ADDR_W] != cmp_src;
                ev_dmis[j]  = data_out[j*DATA_W +: DATA_W] != cmp_dat;
                ev_opass[j] = !ev_amis[j] && !ev_dmis[j];
            end
        end
    end

    always_comb begin
        logic trg;
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            rst_d[i]    = rst_q[i];
            rtmr_d[i]   = rtmr_q[i];
            ev_rpass[i] = 1'b0;
            ev_rto[i]   = 1'b0;
            trg         = 1'b0;
            for (int unsigned j = 0; j < N_PORTS; j++) begin
                if (data_rd[j] && addr_out[j*ADDR_W +: ADDR_W] == ADDR_W'(i)) trg = 1'b1;
            end
            if (!en) begin
                rst_d[i] = ST_IDLE;
            end else if (rst_q[i] == ST_IDLE) begin
                if (trg) begin
                    if (rcv_rdy[i]) begin
                        ev_rpass[i] = 1'b1;
                    end else if (MAX_LAT == 0) begin
                        ev_rto[i] = 1'b1;
                    end else begin
                        rtmr_d[i] = 4'd1;
                        rst_d[i]  = ST_WAIT;
                    end
                end
            end else if (rcv_rdy[i]) begin
                ev_rpass[i] = 1'b1;
                rst_d[i]    = ST_IDLE;
            end else if (rtmr_q[i] == LAT) begin
                ev_rto[i] = 1'b1;
                rst_d[i]  = ST_IDLE;
            end else begin
                rtmr_d[i] = rtmr_q[i] + 4'd1;
            end
        end
    end

    always_comb begin
        logic [7:0]         npass, nfail;
        logic [CNT_W+7:0]   psum, fsum;
        logic [N_PORTS-1:0] evs;
        logic               found;
        logic [2:0]         fcode;
        logic [ADDR_W-1:0]  fport;
        npass = 8'($countones(ev_opass)) + 8'($countones(ev_rpass));
        nfail = 8'($countones(ev_vto)) + 8'($countones(ev_dmis)) + 8'($countones(ev_amis))
              + 8'($countones(ev_rto)) + 8'($countones(ev_con));
        psum  = {8'd0, pass_cnt_q} + {{CNT_W{1'b0}}, npass};
        fsum  = {8'd0, fail_cnt_q} + {{CNT_W{1'b0}}, nfail};
        found = 1'b0;
        fcode = '0;
        fport = '0;
        // Scan order gives lowest code first, then lowest port.
        for (int unsigned c = 0; c < 5; c++) begin
            case (c)
                0:       evs = ev_vto;
                1:       evs = ev_dmis;
                2:       evs = ev_amis;
                3:       evs = ev_rto;
                default: evs = ev_con;
            endcase
            for (int unsigned p = 0; p < N_PORTS; p++) begin
                if (evs[p] && !found) begin
                    found = 1'b1;
                    fcode = 3'(c);
                    fport = ADDR_W'(p);
                end
            end
        end
        if (clr) begin
            err_sticky_d     = '0;
            pass_cnt_d       = '0;
            fail_cnt_d       = '0;
            err_valid_d      = 1'b0;
            first_err_code_d = '0;
            first_err_port_d = '0;
        end else begin
            err_sticky_d     = err_sticky_q | {|ev_con, |ev_rto, |ev_amis, |ev_dmis, |ev_vto};
            pass_cnt_d       = (|psum[CNT_W+7:CNT_W]) ? '1 : psum[CNT_W-1:0];
            fail_cnt_d       = (|fsum[CNT_W+7:CNT_W]) ? '1 : fsum[CNT_W-1:0];
            err_valid_d      = err_valid_q;
            first_err_code_d = first_err_code_q;
            first_err_port_d = first_err_port_q;
            if (!err_valid_q && found) begin
                err_valid_d      = 1'b1;
                first_err_code_d = fcode;
                first_err_port_d = fport;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ost_q            <= '0;
            rst_q            <= '0;
            err_sticky_q     <= '0;
            pass_cnt_q       <= '0;
            fail_cnt_q       <= '0;
            err_valid_q      <= 1'b0;
            first_err_code_q <= '0;
            first_err_port_q <= '0;
            for (int unsigned k = 0; k < N_PORTS; k++) begin
                src_q[k]  <= '0;
                dat_q[k]  <= '0;
                otmr_q[k] <= '0;
                rtmr_q[k] <= '0;
            end
        end else begin
            ost_q            <= ost_d;
            rst_q            <= rst_d;
            err_sticky_q     <= err_sticky_d;
            pass_cnt_q       <= pass_cnt_d;
            fail_cnt_q       <= fail_cnt_d;
            err_valid_q      <= err_valid_d;
            first_err_code_q <= first_err_code_d;
            first_err_port_q <= first_err_port_d;
            for (int unsigned k = 0; k < N_PORTS; k++) begin
                src_q[k]  <= src_d[k];
                dat_q[k]  <= dat_d[k];
                otmr_q[k] <= otmr_d[k];
                rtmr_q[k] <= rtmr_d[k];
            end
        end
    end

    assign err_sticky     = err_sticky_q;
    assign pass_cnt       = pass_cnt_q;
    assign fail_cnt       = fail_cnt_q;
    assign err_valid      = err_valid_q;
    assign first_err_code = first_err_code_q;
    assign first_err_port = first_err_port_q;

endmodule
